dma_bus_master: RTL and testbench

// - Sprite-style DMA engine on the 6502 bus, modelled on NES OAM DMA.
// - Acts as a responder to one CPU write (the trigger register), then becomes bus initiator.
// - Halts the CPU through rdy, copies COUNT bytes from page {PAGE,8'h00} to the fixed

---
 rtl/dma_bus_master.sv | 158 +++++++++++++++
 tb/tb_dma_bus_master.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_bus_master.sv
// dma_bus_master
//   Sprite-style DMA engine for a 6502 bus, modelled on NES OAM DMA. A CPU
//   write to TRIGGER_ADDR latches the source page from the write data. The
//   block then halts the CPU through rdy and takes the bus. It copies COUNT
//   bytes from {page,8'h00} upward to the fixed DEST_ADDR port, alternating a
//   READ cycle and a WRITE cycle for each byte, and finally releases the bus.
//
// Optional feature (macro DMA_ALIGN_EN):
//   When DMA_ALIGN_EN is defined, a free-running parity bit toggles on every
//   phi0 edge. If HALT is left while parity=1, one dummy ALIGN read of
//   {page,8'h00} is inserted before the first READ. When the macro is not
//   defined, there is no parity bit and no ALIGN cycle.
//
// Ports
//   phi0       in   1   system clock, posedge
//   reset_n    in   1   asynchronous active-low reset
//   cpu_addr   in   16  snooped CPU address
//   cpu_dout   in   8   snooped CPU write data
//   cpu_r_w_n  in   1   CPU read/write_n (0 = write)
//   bus_din    in   8   memory read data
//   rdy        out  1   CPU rdy (0 halts the CPU)
//   bus_req    out  1   1 = bus mux selects the dma_* signals
//   dma_addr   out  16  DMA address
//   dma_dout   out  8   DMA write data
//   dma_r_w_n  out  1   DMA read/write_n
//   busy       out  1   1 from trigger capture until the last write completes
module dma_bus_master #(
  parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
  parameter logic [15:0] DEST_ADDR    = 16'h2004,
  parameter int          COUNT        = 256
) (
  input  logic        phi0,
  input  logic        reset_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_r_w_n,
  input  logic [7:0]  bus_din,
  output logic        rdy,
  output logic        bus_req,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_dout,
  output logic        dma_r_w_n,
  output logic        busy
);

  localparam int IW = $clog2(COUNT + 1);
  localparam logic [IW-1:0] LAST = IW'(COUNT - 1);

  typedef enum logic [2:0] {IDLE, HALT, READ, WRITE, ALIGN} state_t;

  state_t        state, state_next;
  logic [7:0]    page;
  logic [IW-1:0] index;
  logic [7:0]    data_latch;
  logic [7:0]    offset;
  logic          trigger;

`ifdef DMA_ALIGN_EN
  logic parity;

  always_ff @(posedge phi0 or negedge reset_n) begin
    if (!reset_n) parity <= 1'b0;
    else          parity <= ~parity;
  end
`endif

  assign trigger = !cpu_r_w_n && (cpu_addr == TRIGGER_ADDR);

  // The low address byte is the index. A counter narrower than 8 bits is
  // zero-extended. A 9-bit counter (COUNT=256) drops bit 8, so the page
  // never carries.
  generate
    if (IW >= 8) begin : g_offset_wide
      assign offset = index[7:0];
    end else begin : g_offset_narrow
      assign offset = {{(8 - IW){1'b0}}, index};
    end
  endgenerate

  // State register
  always_ff @(posedge phi0 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (trigger) state_next = HALT;
`ifdef DMA_ALIGN_EN
      HALT:  state_next = parity ? ALIGN : READ;
      ALIGN: state_next = READ;
`else
      HALT:  state_next = READ;
`endif
      READ:  state_next = WRITE;
      WRITE: state_next = (index == LAST) ? IDLE : READ;
      default: state_next = IDLE;
    endcase
  end

  // Transfer datapath: source page, byte index, read-data latch
  always_ff @(posedge phi0 or negedge reset_n) begin
    if (!reset_n) begin
      page       <= 8'h00;
      index      <= '0;
      data_latch <= 8'h00;
    end else begin
      if (state == IDLE && trigger) begin
        page  <= cpu_dout;
        index <= '0;
      end
      if (state == READ) data_latch <= bus_din;
      if (state == WRITE && index != LAST) index <= index + IW'(1);
    end
  end

  // Output decode
  always_comb begin
    rdy       = 1'b1;
    busy      = 1'b0;
    bus_req   = 1'b0;
    dma_addr  = 16'h0000;
    dma_dout  = 8'h00;
    dma_r_w_n = 1'b1;
    case (state)
      HALT: begin
        rdy  = 1'b0;
        busy = 1'b1;
      end
      READ: begin
        rdy      = 1'b0;
        busy     = 1'b1;
        bus_req  = 1'b1;
        dma_addr = {page, offset};
      end
      WRITE: begin
        rdy       = 1'b0;
        busy      = 1'b1;
        bus_req   = 1'b1;
        dma_addr  = DEST_ADDR;
        dma_dout  = data_latch;
        dma_r_w_n = 1'b0;
      end
`ifdef DMA_ALIGN_EN
      ALIGN: begin
        rdy      = 1'b0;
        busy     = 1'b1;
        bus_req  = 1'b1;
        dma_addr = {page, 8'h00};
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dma_bus_master.sv
// Testbench for dma_bus_master: bus-op vector table, hand-written corner
// sequences (reset, abort, injected trigger, COUNT=4 instance) and randomized
// page copies checked against a per-byte transfer model.
module tb_dma_bus_master;

  logic        phi0 = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_dout = 8'h00;
  logic        cpu_r_w_n = 1'b1;

  logic        rdy, bus_req, dma_r_w_n, busy;
  logic [15:0] dma_addr;
  logic [7:0]  dma_dout, bus_din;
  logic        rdy4, bus_req4, dma_r_w_n4, busy4;
  logic [15:0] dma_addr4;
  logic [7:0]  dma_dout4, bus_din4;

  logic [7:0]  mem [0:65535];

  always #5 phi0 = ~phi0;

  assign bus_din  = mem[dma_addr];
  assign bus_din4 = mem[dma_addr4];

  dma_bus_master dut (
    .phi0(phi0), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_r_w_n(cpu_r_w_n), .bus_din(bus_din), .rdy(rdy), .bus_req(bus_req),
    .dma_addr(dma_addr), .dma_dout(dma_dout), .dma_r_w_n(dma_r_w_n), .busy(busy)
  );

  dma_bus_master #(.TRIGGER_ADDR(16'h4016), .DEST_ADDR(16'h2004), .COUNT(4)) dut4 (
    .phi0(phi0), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .cpu_r_w_n(cpu_r_w_n), .bus_din(bus_din4), .rdy(rdy4), .bus_req(bus_req4),
    .dma_addr(dma_addr4), .dma_dout(dma_dout4), .dma_r_w_n(dma_r_w_n4), .busy(busy4)
  );

  // Selects which instance the transfer checker observes
  logic        sel = 1'b0;
  logic        m_rdy, m_bus_req, m_r_w_n, m_busy;
  logic [15:0] m_addr;
  logic [7:0]  m_dout;
  assign m_rdy     = sel ? rdy4       : rdy;
  assign m_bus_req = sel ? bus_req4   : bus_req;
  assign m_r_w_n   = sel ? dma_r_w_n4 : dma_r_w_n;
  assign m_busy    = sel ? busy4      : busy;
  assign m_addr    = sel ? dma_addr4  : dma_addr;
  assign m_dout    = sel ? dma_dout4  : dma_dout;

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    cpu_addr  = 16'h0000;
    cpu_dout  = 8'h00;
    cpu_r_w_n = 1'b1;
  endtask

  // One CPU bus cycle starting at a negedge; returns 1 ns after the sampling edge
  task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw);
    @(negedge phi0);
    cpu_addr  = a;
    cpu_dout  = d;
    cpu_r_w_n = rw;
    @(posedge phi0);
    #1;
    bus_idle();
  endtask

  // Observes a transfer from 1 ns after its trigger edge. Expected behaviour:
  // one halt cycle, then for byte i a read of {page,i} followed by a write of
  // mem[{page,i}] to 16'h2004, so rdy stays low for 1+2*count cycles.
  // inject_at: sample number at which a second trigger write is driven.
  // reset_at: sample number at which reset is asserted (transfer aborted).
  task automatic run_transfer(input string tag, input logic [7:0] page, input int count,
                              input int inject_at, input logic [7:0] inj_page,
                              input int reset_at);
    logic [7:0] exp_data[$];
    int stall, halt, beat, bad, first_bad, n;
    bit done, aborted;
    stall = 0; halt = 0; beat = 0; bad = 0; first_bad = -1; n = 0;
    done = 0; aborted = 0;
    for (int i = 0; i < count; i++) exp_data.push_back(mem[{page, 8'(i)}]);

    while (!done && n < 3000) begin
      @(negedge phi0);
      if (n == reset_at) begin
        reset_n = 1'b0;
        #1;
        check({tag, " async rdy"}, 32'(m_rdy), 32'd1);
        check({tag, " async bus_req"}, 32'(m_bus_req), 32'd0);
        check({tag, " async busy"}, 32'(m_busy), 32'd0);
        aborted = 1;
        done = 1;
      end else if (m_rdy) begin
        done = 1;
      end else begin
        stall++;
        if (!m_busy) begin
          bad++;
          if (first_bad < 0) first_bad = beat;
        end
        if (!m_bus_req) halt++;
        else begin
          logic        e_rw;
          logic [15:0] e_addr;
          logic        ok;
          e_rw   = (beat % 2 == 0);
          e_addr = e_rw ? {page, 8'(beat / 2)} : 16'h2004;
          ok = (beat < 2 * count) && (m_r_w_n == e_rw) && (m_addr == e_addr);
          if (ok && !e_rw) ok = (m_dout == exp_data[beat / 2]);
          if (!ok) begin
            bad++;
            if (first_bad < 0) first_bad = beat;
          end
          beat++;
        end
      end
      if (n == inject_at) begin
        cpu_addr = 16'h4014; cpu_dout = inj_page; cpu_r_w_n = 1'b0;
      end else if (n == inject_at + 1) begin
        bus_idle();
      end
      n++;
    end
    bus_idle();

    if (aborted) begin
      @(negedge phi0);
      @(negedge phi0);
      reset_n = 1'b1;
      check({tag, " beats before abort"}, 32'(bad), 32'd0);
      $display("transfer %s page %02h: aborted after %0d cycles, %0d beats", tag, page, stall, beat);
      return;
    end
    check({tag, " finished in bound"}, 32'(done), 32'd1);
    check({tag, " stall cycles"}, 32'(stall), 32'(1 + 2 * count));
    check({tag, " halt cycles"}, 32'(halt), 32'd1);
    check({tag, " beat count"}, 32'(beat), 32'(2 * count));
    check($sformatf("%s bad beats (first %0d)", tag, first_bad), 32'(bad), 32'd0);
    check({tag, " busy after"}, 32'(m_busy), 32'd0);
    check({tag, " bus_req after"}, 32'(m_bus_req), 32'd0);
    $display("transfer %s page %02h: stall %0d beats %0d", tag, page, stall, beat);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rw;
    logic        exp_busy;
  } vec_t;

  initial begin
    vec_t vecs[6];
    vecs[0] = '{16'h4014, 8'h02, 1'b1, 1'b0};  // read of trigger: ignored
    vecs[1] = '{16'h4015, 8'h02, 1'b0, 1'b0};  // neighbour address
    vecs[2] = '{16'h2004, 8'h5A, 1'b0, 1'b0};  // CPU write to DEST: not intercepted
    vecs[3] = '{16'h4014, 8'h02, 1'b0, 1'b1};  // page copy of 0200..02FF
    vecs[4] = '{16'h4013, 8'h10, 1'b0, 1'b0};
    vecs[5] = '{16'h4014, 8'h80, 1'b0, 1'b1};

    for (int a = 0; a < 65536; a++) mem[a] = 8'(a * 7 + (a >> 8));
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;
    mem[16'h1000] = 8'h11; mem[16'h1001] = 8'h22;
    mem[16'h1002] = 8'h33; mem[16'h1003] = 8'h44;

    // Reset state
    #1;
    check("reset rdy", 32'(rdy), 32'd1);
    check("reset bus_req", 32'(bus_req), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset dma_addr", 32'(dma_addr), 32'd0);
    check("reset dma_dout", 32'(dma_dout), 32'd0);
    check("reset dma_r_w_n", 32'(dma_r_w_n), 32'd1);
    repeat (3) @(negedge phi0);
    reset_n = 1'b1;

    // Vector table
    foreach (vecs[k]) begin
      cpu_cycle(vecs[k].addr, vecs[k].data, vecs[k].rw);
      check($sformatf("vec%0d busy", k), 32'(busy), 32'(vecs[k].exp_busy));
      check($sformatf("vec%0d rdy", k), 32'(rdy), 32'(!vecs[k].exp_busy));
      check($sformatf("vec%0d bus_req", k), 32'(bus_req), 32'd0);
      if (vecs[k].exp_busy)
        run_transfer($sformatf("vec%0d", k), vecs[k].data, 256, -1, 8'h00, -1);
      else
        $display("vector %0d addr %04h rw %0d: no transfer", k, vecs[k].addr, vecs[k].rw);
    end

    // Trigger and reset in the same cycle: reset wins
    @(negedge phi0);
    cpu_addr = 16'h4014; cpu_dout = 8'h02; cpu_r_w_n = 1'b0;
    reset_n = 1'b0;
    @(posedge phi0);
    #1;
    bus_idle();
    @(negedge phi0);
    reset_n = 1'b1;
    @(negedge phi0);
    check("trig+reset busy", 32'(busy), 32'd0);
    check("trig+reset rdy", 32'(rdy), 32'd1);
    $display("trigger with reset: busy %0d rdy %0d", busy, rdy);

    // Reset 20 cycles into a transfer, then a full restart
    cpu_cycle(16'h4014, 8'h02, 1'b0);
    run_transfer("abort", 8'h02, 256, -1, 8'h00, 20);
    cpu_cycle(16'h4014, 8'h02, 1'b0);
    run_transfer("restart", 8'h02, 256, -1, 8'h00, -1);

    // Second trigger while busy is ignored
    cpu_cycle(16'h4014, 8'h02, 1'b0);
    run_transfer("inject", 8'h02, 256, 30, 8'h10, -1);

    // COUNT=4 instance
    sel = 1'b1;
    cpu_cycle(16'h4016, 8'h10, 1'b0);
    check("count4 main idle", 32'(busy), 32'd0);
    run_transfer("count4", 8'h10, 4, -1, 8'h00, -1);
    sel = 1'b0;

    // Randomized pages and contents, some with injected triggers
    for (int r = 0; r < 5; r++) begin
      logic [7:0] pg;
      int inj;
      pg = 8'($urandom_range(0, 255));
      for (int i = 0; i < 256; i++) mem[{pg, 8'(i)}] = 8'($urandom);
      inj = (r % 2 == 1) ? int'($urandom_range(1, 500)) : -1;
      cpu_cycle(16'h4014, pg, 1'b0);
      run_transfer($sformatf("rand%0d", r), pg, 256, inj, 8'($urandom), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
